// File: rtl/comparator_sweep_checker.sv
// Built-in self-test initiator for a 1-bit comparator: sweeps {A,B} over 00..11,
// samples the 6-bit relation vector after a settle time and accumulates mismatches.
module comparator_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [5:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;
  logic       pass_q, pass_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       mismatch;

  // Y[5:0] = {A<=B, A>=B, A<B, A>B, A!=B, A==B} for the given {A,B}.
  function automatic logic [5:0] golden(input logic [1:0] v);
    case (v)
      2'b00:   golden = 6'b110001;
      2'b01:   golden = 6'b101010;
      2'b10:   golden = 6'b010110;
      default: golden = 6'b110001;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    mask_d   = mask_q;
    pass_d   = pass_q;
    mismatch = (y_in != golden(vec_q));

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          err_d   = 3'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          mask_d = mask_q | (4'b0001 << vec_q);
          err_d  = err_q + 3'd1;
        end
        if (vec_q == 2'd3) begin
          state_d = DONE;
          pass_d  = (err_d == 3'd0);
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = DRIVE;
        end
      end
    endcase

    // Outputs are derived from the next state so they are registered yet aligned with it.
    busy_d       = (state_d == DRIVE) || (state_d == CHECK);
    done_d       = (state_d == DONE);
    {a_d, b_d}   = busy_d ? vec_d : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= 3'd0;
      mask_q  <= 4'd0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Bench for comparator_sweep_checker: instance 0 (SETTLE=1) with a fault-injecting comparator
// model, instance 1 (SETTLE=3) with a comparator whose output glitches after each operand change.
module tb_comparator_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       start_r [2];
  logic       rstn_r  [2];
  logic [5:0] y0, y1;
  logic       a_w [2], b_w [2], busy_w [2], done_w [2], pass_w [2];
  logic [2:0] err_w  [2];
  logic [3:0] mask_w [2];

  int checks = 0;
  int errors = 0;

  logic       zero_mode;
  logic [3:0] cmask;
  logic [5:0] flip;

  comparator_sweep_checker #(.SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rstn_r[0]), .start(start_r[0]),
    .a_out(a_w[0]), .b_out(b_w[0]), .y_in(y0),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .fail_mask(mask_w[0])
  );

  comparator_sweep_checker #(.SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rstn_r[1]), .start(start_r[1]),
    .a_out(a_w[1]), .b_out(b_w[1]), .y_in(y1),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .fail_mask(mask_w[1])
  );

  // Ideal 1-bit comparator, straight from the relation definitions.
  function automatic logic [5:0] ideal(input logic a, input logic b);
    int x, y;
    x = a ? 1 : 0;
    y = b ? 1 : 0;
    ideal    = '0;
    ideal[0] = (x == y);
    ideal[1] = (x != y);
    ideal[2] = (x > y);
    ideal[3] = (x < y);
    ideal[4] = (x >= y);
    ideal[5] = (x <= y);
  endfunction

  // Comparator for instance 0: stuck-at-zero, or selected vectors XORed with a fault pattern.
  always_comb begin
    y0 = ideal(a_w[0], b_w[0]);
    if (zero_mode) y0 = '0;
    else if (cmask[{a_w[0], b_w[0]}]) y0 = y0 ^ flip;
  end

  // Comparator for instance 1: random garbage for the first two cycles after any operand change.
  int         age = 100;
  logic [2:0] prev_key = 3'b000;
  always @(negedge clk) begin
    if ({busy_w[1], a_w[1], b_w[1]} != prev_key) age = 0;
    else if (age < 100) age++;
    prev_key = {busy_w[1], a_w[1], b_w[1]};
    y1 = (age < 2) ? 6'($urandom) : ideal(a_w[1], b_w[1]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requests a sweep on instance u and follows it until done (bounded); checks the operand trace.
  task automatic run(input int u, input int poke_at, output int lat);
    int s;
    int last;
    s    = (u == 1) ? 3 : 1;
    last = 4 * (s + 1);
    start_r[u] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        start_r[u] = 1'b0;
        check("busy_rise", busy_w[u], 1);
        check("err_cleared", err_w[u], 0);
        check("mask_cleared", mask_w[u], 0);
        check("pass_cleared", pass_w[u], 0);
      end
      if (lat == poke_at)     start_r[u] = 1'b1;
      if (lat == poke_at + 1) start_r[u] = 1'b0;
      if (lat <= last) check("trace_ab", {a_w[u], b_w[u]}, (lat - 1) / (s + 1));
    end while (!done_w[u] && lat < 60);
  endtask

  task automatic verify(input int u, input int lat, input int exp_lat, input int exp_err,
                        input logic [3:0] exp_mask);
    check("latency", lat, exp_lat);
    check("done_pulse", done_w[u], 1);
    check("busy_fall", busy_w[u], 0);
    check("err_count", err_w[u], exp_err);
    check("fail_mask", mask_w[u], exp_mask);
    check("pass", pass_w[u], exp_err == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    logic [3:0] rmask;

    start_r[0] = 1'b0; start_r[1] = 1'b0;
    rstn_r[0]  = 1'b0; rstn_r[1]  = 1'b0;
    zero_mode  = 1'b0; cmask = 4'd0; flip = 6'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_a", a_w[u], 0);
      check("rst_b", b_w[u], 0);
      check("rst_busy", busy_w[u], 0);
      check("rst_done", done_w[u], 0);
      check("rst_pass", pass_w[u], 0);
      check("rst_err", err_w[u], 0);
      check("rst_mask", mask_w[u], 0);
    end
    @(negedge clk);
    rstn_r[0] = 1'b1; rstn_r[1] = 1'b1;
    @(negedge clk);

    // Ideal comparator.
    run(0, 0, lat);
    verify(0, lat, 9, 0, 4'h0);
    @(posedge clk); #1;
    check("done_single_cycle", done_w[0], 0);
    check("pass_held", pass_w[0], 1);

    // Stuck-at-zero Y.
    zero_mode = 1'b1;
    run(0, 0, lat);
    verify(0, lat, 9, 4, 4'hF);
    zero_mode = 1'b0;
    @(posedge clk); #1;

    // Y[2] corrupted only for {A,B}=10.
    cmask = 4'b0100; flip = 6'b000100;
    run(0, 0, lat);
    verify(0, lat, 9, 1, 4'b0100);
    cmask = 4'd0;
    @(posedge clk); #1;

    // start pulsed while in DRIVE is ignored.
    run(0, 3, lat);
    verify(0, lat, 9, 0, 4'h0);
    @(posedge clk); #1;

    // start held through DONE: back-to-back sweep with cleared results.
    zero_mode = 1'b1;
    run(0, 0, lat);
    verify(0, lat, 9, 4, 4'hF);
    zero_mode = 1'b0;
    run(0, 0, lat);
    verify(0, lat, 9, 0, 4'h0);
    @(posedge clk); #1;

    // Reset asserted while vector 10 is driven.
    zero_mode = 1'b1;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if ({a_w[0], b_w[0]} == 2'b10) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reach_vec10", seen, 1);
    #2;
    rstn_r[0] = 1'b0;
    #1;
    check("mid_rst_a", a_w[0], 0);
    check("mid_rst_b", b_w[0], 0);
    check("mid_rst_busy", busy_w[0], 0);
    check("mid_rst_done", done_w[0], 0);
    check("mid_rst_pass", pass_w[0], 0);
    check("mid_rst_err", err_w[0], 0);
    check("mid_rst_mask", mask_w[0], 0);
    @(negedge clk);
    rstn_r[0] = 1'b1;
    zero_mode = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_w[0] || busy_w[0]) seen = 1;
    end
    check("no_resume_after_reset", seen, 0);

    // Random fault patterns on random vectors.
    repeat (6) begin
      rmask = 4'($urandom);
      cmask = rmask;
      flip  = 6'($urandom_range(1, 63));
      run(0, 0, lat);
      verify(0, lat, 9, $countones(rmask), rmask);
      @(posedge clk); #1;
    end
    cmask = 4'd0;

    // SETTLE=3 with a glitching ideal comparator.
    run(1, 0, lat);
    verify(1, lat, 17, 0, 4'h0);
    @(posedge clk); #1;
    run(1, 5, lat);
    verify(1, lat, 17, 0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
